// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-port data memory between the CPU MEM stage (M0) and the
// DMA/debug port (M1). Registered round-robin arbitration with an optional, length-bounded bus
// lock for bursts.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_req/wr/addr/be/wdata    requester X access (X = 0, 1); req held until ack
//   mX_lock                    requester X wants to keep ownership after this access
//   mX_ack, mX_rdata           access performed this cycle; read word (0 when no ack)
//   dm_wr/addr/be/din          data memory drive
//   dm_dout                    data memory read word (combinational)
//   cpu_stall                  M0 requesting but not acknowledged
//   owner                      debug state code: 00 idle, 01 M0, 10 M1
module dm_port_arbiter #(
    parameter int unsigned LOCK_MAX = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,

    output logic        dm_wr,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout,

    output logic        cpu_stall,
    output logic [1:0]  owner
);

    // Encoding doubles as the debug owner code.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_MAX - 1);

    state_e           state;
    logic             rr_ptr;    // last owner: 0 = M0, 1 = M1
    logic [CNT_W-1:0] lock_cnt;

    // Current owner's request/lock and the other master's request, so the two
    // ownership states share one set of transition rules.
    logic cur_req;
    logic cur_lock;
    logic oth_req;

    always_comb begin
        cur_req  = 1'b0;
        cur_lock = 1'b0;
        oth_req  = 1'b0;
        unique case (state)
            StOwn0: begin
                cur_req  = m0_req;
                cur_lock = m0_lock;
                oth_req  = m1_req;
            end
            StOwn1: begin
                cur_req  = m1_req;
                cur_lock = m1_lock;
                oth_req  = m0_req;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            rr_ptr   <= 1'b1;
            lock_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    lock_cnt <= '0;
                    // On a tie the master that did not own last wins.
                    if (m0_req && (!m1_req || rr_ptr)) begin
                        state  <= StOwn0;
                        rr_ptr <= 1'b0;
                    end else if (m1_req) begin
                        state  <= StOwn1;
                        rr_ptr <= 1'b1;
                    end
                end
                StOwn0, StOwn1: begin
                    if (cur_req && cur_lock && (lock_cnt < LockLast)) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end else begin
                        // Lock absent or expired: hand over directly if the other side waits.
                        lock_cnt <= '0;
                        if (oth_req) begin
                            if (state == StOwn0) begin
                                state  <= StOwn1;
                                rr_ptr <= 1'b1;
                            end else begin
                                state  <= StOwn0;
                                rr_ptr <= 1'b0;
                            end
                        end else if (!cur_req) begin
                            state <= StIdle;
                        end
                    end
                end
                default: begin
                    state    <= StIdle;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    // Memory drive and acks depend only on the registered owner, never on req in idle.
    always_comb begin
        dm_wr   = 1'b0;
        dm_addr = '0;
        dm_be   = '0;
        dm_din  = '0;
        m0_ack  = 1'b0;
        m1_ack  = 1'b0;
        unique case (state)
            StOwn0: begin
                dm_wr   = m0_wr & m0_req;
                dm_addr = m0_addr;
                dm_be   = m0_be;
                dm_din  = m0_wdata;
                m0_ack  = m0_req;
            end
            StOwn1: begin
                dm_wr   = m1_wr & m1_req;
                dm_addr = m1_addr;
                dm_be   = m1_be;
                dm_din  = m1_wdata;
                m1_ack  = m1_req;
            end
            default: ;
        endcase
    end

    assign m0_rdata  = m0_ack ? dm_dout : 32'h0;
    assign m1_rdata  = m1_ack ? dm_dout : 32'h0;
    assign cpu_stall = m0_req & ~m0_ack;
    assign owner     = state;

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port data memory (32-bit word, 4 byte enables, combinational read, write on rising clk) between two requesters: M0 = CPU MEM stage, M1 = DMA/debug port.
- Registered round-robin arbitration with optional bus lock for bursts.
- A lock-length counter bounds how long one master can hold the memory.
- Sits between the MEM-stage byte-enable/extend logic and the DM array.
- Drives the CPU stall signal.

Parameters:
- LOCK_MAX, 8: maximum consecutive accesses a locked master may perform before a forced release; legal range 1..255.
- CNT_W, 8: width of the lock counter; must hold LOCK_MAX.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  M0 access request; held until ack.
- m0_wr  in  1  M0 write (1) / read (0).
- m0_addr  in  32  M0 byte address.
- m0_be  in  4  M0 byte enables.
- m0_wdata  in  32  M0 write data (already lane-replicated).
- m0_lock  in  1  M0 requests to keep ownership after the current access.
- m0_ack  out  1  M0 access performed this cycle.
- m0_rdata  out  32  M0 read word; valid when m0_ack=1.
- m1_req, m1_wr, m1_addr, m1_be, m1_wdata, m1_lock, m1_ack, m1_rdata: same as the M0 ports, for M1.
- dm_wr  out  1  DM write strobe.
- dm_addr  out  32  DM address.
- dm_be  out  4  DM byte enables.
- dm_din  out  32  DM write data.
- dm_dout  in  32  DM read word (combinational).
- cpu_stall  out  1  m0_req & ~m0_ack.
- owner  out  2  state code for debug: 00 = IDLE, 01 = M0, 10 = M1.

Behaviour:
- States: IDLE, OWN0, OWN1. State register, rr_ptr (1 bit, last owner) and lock_cnt (CNT_W bits) are all cleared asynchronously when rst_n=0.
- Reset values: state = IDLE, rr_ptr = 1 (M0 wins the first tie), lock_cnt = 0.
- Outputs while in reset: all acks 0, dm_wr 0, owner 00.

DM drive:
- In OWNx, dm_addr, dm_be and dm_wdata come from Mx. dm_wr = mx_wr & mx_req.
- In IDLE: dm_wr = 0, dm_be = 0, dm_addr = 0.
- The write commits at the rising edge ending the OWNx cycle.
- mx_rdata = dm_dout in the same cycle as mx_ack, and is forced to 0 when mx_ack = 0.

Ack:
- mx_ack = (state == OWNx) & mx_req. There is one access per cycle.
- If a master drops its request while it owns the memory: no ack, no write.

Arbitration (registered, one cycle grant latency from IDLE):
- IDLE, only Mx requesting -> OWNx.
- IDLE, both requesting -> the master other than rr_ptr.
- IDLE, none requesting -> stay IDLE.
- Ownership change means rr_ptr is updated to the new owner in the same edge.

Next state from OWNx, evaluated on the edge that ends the access:
- Keep ownership if mx_req & mx_lock & (lock_cnt < LOCK_MAX-1). In that case lock_cnt increments.
- Else if the other master is requesting, go directly to OWN(other) and clear lock_cnt. There is no IDLE bubble.
- Else if mx_req (unlocked, or lock expired), stay in OWNx and clear lock_cnt. This is back-to-back service.
- Else go to IDLE and clear lock_cnt.
- Forced release: when lock_cnt reaches LOCK_MAX-1 and the other master is waiting, the switch is mandatory even if mx_lock = 1.
- Fairness consequence: with both masters continuously requesting and neither locking, ownership alternates every cycle.

Other rules:
- No combinational path from req to the DM address in IDLE. Grant is always state-based.
- Address, be and wdata are not checked for alignment; that is the MEM-stage logic's job.
- Reset mid-access:
  - A write in the same cycle rst_n falls is not guaranteed.
  - The arbiter returns to IDLE immediately.
  - Requesters must re-issue after reset.

Test Plan:
- Reset, then M0 read only:
  - m0_req = 1 at cycle 0 gives owner = 01 at cycle 1.
  - m0_ack = 1 at cycle 1, with m0_rdata equal to the DM word at m0_addr (preloaded 0x12345678 at 0x10 -> 0x12345678).
  - cpu_stall = 1 at cycle 0 only.
- Simultaneous first requests from IDLE after reset:
  - M0 is granted first, then M1 on the next cycle.
  - Acks alternate m0, m1, m0, ... while both requests are held.
- M1 locked burst with LOCK_MAX = 4 and M0 requesting throughout:
  - M1 gets exactly 4 consecutive acks, then M0 gets 1 ack.
  - cpu_stall is high for the whole burst.
- M0 write then M1 read of the same word:
  - M0 writes 0xAABBCCDD with be = 4'b0100 to 0x20, preload 0.
  - M1 then reads 0x20 and gets m1_rdata = 0x00BB0000.
- Request withdrawal: M1 owns, drops m1_req, no other request -> no ack, dm_wr = 0, next state IDLE (owner = 00).
- Asynchronous reset while OWN1 locked, mid-cycle:
  - owner = 00 and all acks = 0 immediately, without waiting for a clock edge.
  - After rst_n rises with both masters requesting, M0 is granted first.
